// File: rtl/stream_fifo_packer_if.sv
// rtl/stream_fifo_packer_if.sv - byte stream in, FIFO write port out, for the write-side packer
interface stream_fifo_packer_if #(
    parameter int IW    = 8,
    parameter int RATIO = 4,
    parameter int ASIZE = 10
);
    // narrow input stream
    logic [IW-1:0]       s_data;
    logic                s_valid;
    logic                s_last;
    logic                s_ready;

    // FIFO write port
    logic [IW*RATIO-1:0] fifo_wdata;
    logic                fifo_w_en;
    logic                fifo_w_full;
    logic [ASIZE-1:0]    fifo_wuse;

    // upstream source plus FIFO side, as seen from outside the packer
    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready,
        input  fifo_wdata,
        input  fifo_w_en,
        output fifo_w_full,
        output fifo_wuse
    );

    // the packer itself
    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready,
        output fifo_wdata,
        output fifo_w_en,
        input  fifo_w_full,
        input  fifo_wuse
    );
endinterface

// File: rtl/stream_fifo_packer.sv
// rtl/stream_fifo_packer.sv - packs RATIO narrow beats per FIFO word behind a one-word holding register
module stream_fifo_packer #(
    parameter int IW       = 8,
    parameter int RATIO    = 4,
    parameter int ASIZE    = 10,
    parameter int AF_LEVEL = 1000
) (
    input  logic                 wclk,
    input  logic                 rst_n,
    stream_fifo_packer_if.slave  bus,
    output logic                 almost_full,
    output logic [15:0]          word_cnt,
    output logic [15:0]          pkt_cnt
);
    localparam int DSIZE = IW * RATIO;
    localparam int IDXW  = (RATIO > 1) ? $clog2(RATIO) : 1;

    // FILL: holding register empty; HOLD: holding register owns a word for the FIFO
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [DSIZE-1:0]  pack_q;
    logic [IDXW-1:0]   idx_q;
    logic [DSIZE-1:0]  out_q;
    logic              af_q;
    logic [15:0]       word_cnt_q;
    logic [15:0]       pkt_cnt_q;

    logic              out_valid;
    logic              w_en;
    logic              ready;
    logic              accept;
    logic              last_lane;
    logic              complete;
    logic [DSIZE-1:0]  merged;

    // the holding register is valid exactly when the FSM is in HOLD
    assign out_valid = (state_q == HOLD);

    // a write happens whenever a word is held and the FIFO has room this cycle;
    // a beat may enter only if the holding register is free or drains now
    assign w_en      = out_valid & ~bus.fifo_w_full;
    assign ready     = rst_n & (~out_valid | w_en);
    assign accept    = bus.s_valid & ready;
    assign last_lane = (idx_q == IDXW'(RATIO - 1));
    assign complete  = accept & (last_lane | bus.s_last);

    assign bus.fifo_wdata = out_q;
    assign bus.fifo_w_en  = w_en;
    assign bus.s_ready    = ready;

    assign almost_full = af_q;
    assign word_cnt    = word_cnt_q;
    assign pkt_cnt     = pkt_cnt_q;

    // completed word: lanes below idx from pack_q, the incoming beat at idx, zeros above
    always_comb begin
        merged = '0;
        for (int l = 0; l < RATIO; l++) begin
            if (IDXW'(l) < idx_q) begin
                merged[l*IW +: IW] = pack_q[l*IW +: IW];
            end else if (IDXW'(l) == idx_q) begin
                merged[l*IW +: IW] = bus.s_data;
            end
        end
    end

    // next state: completion always lands in HOLD, a bare drain returns to FILL
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (complete) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (complete) begin
                    state_d = HOLD;
                end else if (w_en) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // FSM state register
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // packing datapath: collect lanes, hand a finished word to the holding register
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q <= '0;
            idx_q  <= '0;
            out_q  <= '0;
        end else if (accept) begin
            if (complete) begin
                out_q  <= merged;
                pack_q <= '0;
                idx_q  <= '0;
            end else begin
                pack_q[idx_q*IW +: IW] <= bus.s_data;
                idx_q                  <= idx_q + IDXW'(1);
            end
        end
    end

    // status: registered occupancy threshold and wrapping write/packet counters
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            af_q       <= 1'b0;
            word_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            af_q <= (bus.fifo_wuse >= ASIZE'(AF_LEVEL));
            if (w_en) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
            if (accept && bus.s_last) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_stream_fifo_packer.sv
// tb/tb_stream_fifo_packer.sv - self-checking bench for stream_fifo_packer
module tb_stream_fifo_packer;
    localparam int IW    = 8;
    localparam int RATIO = 4;
    localparam int ASIZE = 10;
    localparam int AF    = 1000;

    logic        wclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        almost_full;
    logic [15:0] word_cnt;
    logic [15:0] pkt_cnt;

    always #5 wclk = ~wclk;

    stream_fifo_packer_if #(.IW(IW), .RATIO(RATIO), .ASIZE(ASIZE)) bus ();

    stream_fifo_packer #(
        .IW(IW), .RATIO(RATIO), .ASIZE(ASIZE), .AF_LEVEL(AF)
    ) dut (
        .wclk        (wclk),
        .rst_n       (rst_n),
        .bus         (bus),
        .almost_full (almost_full),
        .word_cnt    (word_cnt),
        .pkt_cnt     (pkt_cnt)
    );

    int checks = 0;
    int errors = 0;

    // model state: words awaiting write, partial word, counters, registered almost-full
    logic [31:0] exp_q[$];
    logic [31:0] acc;
    int          acc_idx;
    logic [15:0] m_wc;
    logic [15:0] m_pc;
    logic        m_af;
    logic [31:0] wr_log[$];
    int          stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        acc     = '0;
        acc_idx = 0;
        m_wc    = '0;
        m_pc    = '0;
        m_af    = 1'b0;
    endtask

    // per-cycle compare and model advance, mid-cycle when outputs are settled
    always @(negedge wclk) begin
        logic exp_wen;
        logic exp_ready;
        if (!rst_n) begin
            model_clear();
            chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
            chk("rst_w_en", 32'(bus.fifo_w_en), 32'd0);
            chk("rst_wdata", bus.fifo_wdata, 32'd0);
            chk("rst_af", 32'(almost_full), 32'd0);
            chk("rst_word_cnt", 32'(word_cnt), 32'd0);
            chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        end else begin
            exp_wen   = (exp_q.size() > 0) && !bus.fifo_w_full;
            exp_ready = (exp_q.size() == 0) || !bus.fifo_w_full;
            chk("s_ready", 32'(bus.s_ready), 32'(exp_ready));
            chk("w_en", 32'(bus.fifo_w_en), 32'(exp_wen));
            chk("almost_full", 32'(almost_full), 32'(m_af));
            chk("word_cnt", 32'(word_cnt), 32'(m_wc));
            chk("pkt_cnt", 32'(pkt_cnt), 32'(m_pc));
            if (exp_wen) begin
                chk("wdata", bus.fifo_wdata, exp_q[0]);
                wr_log.push_back(bus.fifo_wdata);
                void'(exp_q.pop_front());
                m_wc = m_wc + 16'd1;
            end
            if (bus.s_valid && exp_ready) begin
                acc = acc | (32'(bus.s_data) << (8 * acc_idx));
                if (bus.s_last) m_pc = m_pc + 16'd1;
                if (acc_idx == RATIO - 1 || bus.s_last) begin
                    exp_q.push_back(acc);
                    acc     = '0;
                    acc_idx = 0;
                end else begin
                    acc_idx++;
                end
            end
            m_af = (bus.fifo_wuse >= ASIZE'(AF));
        end
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        repeat (n) tick();
    endtask

    // offer one beat and keep it on the bus until accepted (bounded)
    task automatic send_beat(input logic [7:0] d, input logic last);
        bit done = 0;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        bus.s_last  = last;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge wclk);
            if (bus.s_ready) done = 1;
            else stalls++;
            tick();
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.s_data      = '0;
        bus.s_valid     = 1'b0;
        bus.s_last      = 1'b0;
        bus.fifo_w_full = 1'b0;
        bus.fifo_wuse   = '0;
        stalls          = 0;
        model_clear();

        repeat (3) tick();
        chk("reset_s_ready_low", 32'(bus.s_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("s_ready_after_release", 32'(bus.s_ready), 32'd1);

        // four full beats
        wr_log.delete();
        stalls = 0;
        send_beat(8'h11, 0); send_beat(8'h22, 0); send_beat(8'h33, 0); send_beat(8'h44, 0);
        idle(4);
        chk("t1_writes", wr_log.size(), 32'd1);
        if (wr_log.size() > 0) chk("t1_word", wr_log[0], 32'h44332211);
        chk("t1_stalls", stalls, 32'd0);
        chk("t1_word_cnt", 32'(word_cnt), 32'd1);

        // short packet, then s_last on lane 0
        wr_log.delete();
        send_beat(8'hA1, 0); send_beat(8'hA2, 1);
        send_beat(8'hB1, 1);
        idle(4);
        chk("t2_writes", wr_log.size(), 32'd2);
        if (wr_log.size() > 1) begin
            chk("t2_word0", wr_log[0], 32'h0000A2A1);
            chk("t2_word1", wr_log[1], 32'h000000B1);
        end
        chk("t2_pkt_cnt", 32'(pkt_cnt), 32'd2);

        // FIFO full during eight beats
        wr_log.delete();
        bus.fifo_w_full = 1'b1;
        fork
            begin
                repeat (12) @(negedge wclk);
                chk("t3_held_wen", 32'(bus.fifo_w_en), 32'd0);
                chk("t3_held_ready", 32'(bus.s_ready), 32'd0);
                chk("t3_held_data", bus.fifo_wdata, 32'h04030201);
                tick();
                bus.fifo_w_full = 1'b0;
            end
            begin
                for (int i = 1; i <= 8; i++) send_beat(8'(i), 0);
            end
        join
        idle(4);
        chk("t3_writes", wr_log.size(), 32'd2);
        if (wr_log.size() > 1) begin
            chk("t3_word0", wr_log[0], 32'h04030201);
            chk("t3_word1", wr_log[1], 32'h08070605);
        end

        // sixteen continuous beats
        wr_log.delete();
        stalls = 0;
        for (int i = 0; i < 16; i++) send_beat(8'(8'h30 + i), 0);
        idle(4);
        chk("t4_stalls", stalls, 32'd0);
        chk("t4_writes", wr_log.size(), 32'd4);
        if (wr_log.size() > 3) chk("t4_word3", wr_log[3], 32'h3F3E3D3C);
        chk("t4_word_cnt", 32'(word_cnt), 32'd9);

        // almost_full threshold
        bus.fifo_wuse = 10'd999;
        tick();
        bus.fifo_wuse = 10'd1000;
        @(negedge wclk);
        chk("t5_af_999", 32'(almost_full), 32'd0);
        chk("t5_ready_999", 32'(bus.s_ready), 32'd1);
        tick();
        @(negedge wclk);
        chk("t5_af_1000", 32'(almost_full), 32'd1);
        chk("t5_ready_1000", 32'(bus.s_ready), 32'd1);
        tick();
        bus.fifo_wuse = '0;
        tick();

        // reset while a word is being written, then while mid-word
        send_beat(8'h61, 0); send_beat(8'h62, 0); send_beat(8'h63, 0); send_beat(8'h64, 0);
        chk("t6_wen_before", 32'(bus.fifo_w_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_wen_async", 32'(bus.fifo_w_en), 32'd0);
        chk("t6_ready_async", 32'(bus.s_ready), 32'd0);
        chk("t6_wdata_async", bus.fifo_wdata, 32'd0);
        idle(2);
        rst_n = 1'b1;
        tick();
        send_beat(8'h71, 0); send_beat(8'h72, 0);
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_ready_mid", 32'(bus.s_ready), 32'd0);
        idle(2);
        rst_n = 1'b1;
        tick();
        wr_log.delete();
        send_beat(8'h55, 0); send_beat(8'h56, 0); send_beat(8'h57, 0); send_beat(8'h58, 0);
        idle(4);
        chk("t6_writes", wr_log.size(), 32'd1);
        if (wr_log.size() > 0) chk("t6_word", wr_log[0], 32'h58575655);
        chk("t6_word_cnt", 32'(word_cnt), 32'd1);

        // randomized traffic with random back-pressure and occupancy
        for (int c = 0; c < 800; c++) begin
            bus.s_valid     = ($urandom_range(0, 3) != 0);
            bus.s_data      = 8'($urandom);
            bus.s_last      = ($urandom_range(0, 5) == 0);
            bus.fifo_w_full = ($urandom_range(0, 2) == 0);
            bus.fifo_wuse   = 10'($urandom_range(990, 1023));
            if (c == 400) begin
                rst_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        bus.fifo_w_full = 1'b0;
        idle(6);
        chk("rand_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_fifo_packer.md
Name: stream_fifo_packer

Overview:
- Write-side feeder for the dual-clock stream FIFO. Sits in the wclk domain directly upstream of the FIFO write port.
- Accepts a narrow valid/ready byte stream and packs RATIO input beats into one FIFO-width word, lane 0 in the LSBs.
- Honours the FIFO's combinational full flag through a one-word holding register. Reports occupancy-based almost-full and write/packet counters.

Parameters:
- IW, 8, input beat width in bits.
- RATIO, 4, input beats per FIFO word (>=2). FIFO data width DSIZE = IW*RATIO.
- ASIZE, 10, FIFO address width. Must match the FIFO's wuse width.
- AF_LEVEL, 1000, almost_full threshold in FIFO words (< 2^ASIZE).

Ports:
- wclk  in  1  write-domain clock.
- rst_n  in  1  reset.
- s_data  in  IW  input beat data.
- s_valid  in  1  input beat valid.
- s_last  in  1  last beat of a packet. Flushes the partial word.
- s_ready  out  1  beat accepted when s_valid & s_ready.
- fifo_wdata  out  IW*RATIO  to FIFO wdata.
- fifo_w_en  out  1  to FIFO w_en.
- fifo_w_full  in  1  from FIFO w_full (combinational there).
- fifo_wuse  in  ASIZE  from FIFO wuse.
- almost_full  out  1  registered: fifo_wuse >= AF_LEVEL.
- word_cnt  out  16  FIFO words written, wraps modulo 2^16.
- pkt_cnt  out  16  s_last beats accepted, wraps modulo 2^16.

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock wclk. All registers clear.
- While reset is asserted and after release: fifo_w_en=0, fifo_wdata=0, almost_full=0, word_cnt=0, pkt_cnt=0. s_ready=0 while rst_n low and 1 in the first cycle after release.
- Registers:
  - pack_q (IW*RATIO).
  - lane index idx (0..RATIO-1).
  - out_q (IW*RATIO).
  - out_valid.
  - FSM state: FILL (out_valid=0) or HOLD (out_valid=1).
- Output, combinational:
  - fifo_wdata = out_q.
  - fifo_w_en = out_valid & ~fifo_w_full.
  - s_ready = rst_n & (~out_valid | fifo_w_en).
- Accept, on s_valid & s_ready: lane idx of pack_q <= s_data.
  - If idx==RATIO-1 or s_last, the word completes:
    - out_q <= merged word (pack_q with the new lane). Lanes above idx are forced to 0.
    - out_valid <= 1; idx <= 0; pack_q <= 0.
  - Otherwise idx <= idx+1.
- Drain: when fifo_w_en=1 and no word completes that cycle, out_valid <= 0. A word completing in the same cycle as a drain keeps out_valid=1 with the new out_q. No bubble; back-to-back full words run at 1 word per RATIO cycles.
- FSM transitions:
  - FILL->HOLD on word complete.
  - HOLD->FILL on drain without completion.
  - HOLD->HOLD on simultaneous drain+complete, or while fifo_w_full=1.
- Full: while fifo_w_full=1 in HOLD, out_q is stable and s_ready=0. Partial lanes already in pack_q are kept. No beat is ever dropped or duplicated.
- s_last on lane 0: emits a word with only lane 0 populated and upper lanes zero.
- s_last with s_valid=0 is ignored.
- word_cnt increments on fifo_w_en. pkt_cnt increments on accepted s_last. Both wrap 0xFFFF->0x0000.
- almost_full is registered each cycle from fifo_wuse and is status only; it does not gate s_ready.
- Reset mid-operation: pending pack_q and out_q contents are discarded. fifo_w_en drops immediately (asynchronous).

Test Plan:
- Reset, then 4 beats 0x11,0x22,0x33,0x44 with s_valid continuous and fifo_w_full=0 -> s_ready stays 1; fifo_w_en=1 for one cycle, the cycle after beat 4, with fifo_wdata=0x44332211; word_cnt=1.
- Beats 0xA1,0xA2 with s_last on 0xA2 -> one write of 0x0000A2A1; pkt_cnt=1; idx back to 0; the next beat lands in lane 0.
- Hold fifo_w_full=1 while 8 beats 0x01..0x08 are offered -> first word 0x04030201 held with fifo_w_en=0 and s_ready=0 after beat 4. Release full -> words 0x04030201 then 0x08070605 written in order; no loss.
- Continuous 16 beats, full=0 -> 4 writes spaced 4 cycles apart; s_ready never deasserts; word_cnt=4.
- fifo_wuse driven 999 then 1000 -> almost_full 0, then 1 one cycle later; s_ready unaffected.
- Assert rst_n=0 after 2 beats of a word -> fifo_w_en=0 and s_ready=0 immediately. After release, beats 0x55..0x58 produce 0x58575655 with no residue from the earlier beats.
